// File: rtl/munoc_axi4_write_order_guard_if.sv
// AXI4 write-address/data/response channel bundle used on both sides of the write order guard.
interface munoc_axi4_write_order_guard_if #(
    parameter int BW_AXI_TID       = 4,
    parameter int BW_PLATFORM_ADDR = 32,
    parameter int BW_NODE_DATA     = 32
);
    logic [BW_AXI_TID-1:0]       awid;
    logic [BW_PLATFORM_ADDR-1:0] awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awvalid;
    logic                        awready;

    logic [BW_NODE_DATA-1:0]     wdata;
    logic [BW_NODE_DATA/8-1:0]   wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        wready;

    logic [BW_AXI_TID-1:0]       bid;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/munoc_axi4_write_order_guard.sv
// Holds upstream W beats until their AW has been accepted downstream and regenerates WLAST
// from the queued AWLEN values; a sticky flag records masters whose WLAST disagrees.
module munoc_axi4_write_order_guard #(
    parameter int BW_AXI_TID       = 4,
    parameter int BW_PLATFORM_ADDR = 32,
    parameter int BW_NODE_DATA     = 32,
    parameter int MAX_OUTSTANDING  = 4,
    localparam int PTR_W = $clog2(MAX_OUTSTANDING),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic clk,
    input  logic rst,
    munoc_axi4_write_order_guard_if.slave  sx4,
    munoc_axi4_write_order_guard_if.master rx4,
    output logic [CNT_W-1:0] pending_count,
    output logic             wlast_error
);

    logic [7:0]       len_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [7:0]       beat_cnt_reg, beat_cnt_next;
    logic             wlast_error_reg, wlast_error_next;

    logic       full;
    logic       empty;
    logic [7:0] fifo_head;
    logic       beat_last;
    logic       push;
    logic       w_hs;
    logic       pop;

    // full/empty come from the registered count, so a pop or push only takes effect next cycle.
    assign full      = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign empty     = (count_reg == '0);
    assign fifo_head = len_mem[rd_ptr_reg];
    assign beat_last = (beat_cnt_reg == fifo_head);

    // Channel handshakes, all forced idle while reset is held.
    assign rx4.awvalid = sx4.awvalid & ~full & ~rst;
    assign sx4.awready = rx4.awready & ~full & ~rst;
    assign rx4.wvalid  = sx4.wvalid & ~empty & ~rst;
    assign sx4.wready  = rx4.wready & ~empty & ~rst;
    assign sx4.bvalid  = rx4.bvalid & ~rst;
    assign rx4.bready  = sx4.bready & ~rst;

    assign rx4.awid    = BW_AXI_TID'(sx4.awid);
    assign rx4.awaddr  = BW_PLATFORM_ADDR'(sx4.awaddr);
    assign rx4.awlen   = sx4.awlen;
    assign rx4.awsize  = sx4.awsize;
    assign rx4.awburst = sx4.awburst;
    assign rx4.wdata   = BW_NODE_DATA'(sx4.wdata);
    assign rx4.wstrb   = sx4.wstrb;
    assign rx4.wlast   = beat_last;
    assign sx4.bid     = rx4.bid;
    assign sx4.bresp   = rx4.bresp;

    assign push = rx4.awvalid & rx4.awready;
    assign w_hs = rx4.wvalid & rx4.wready;
    assign pop  = w_hs & beat_last;

    assign pending_count = count_reg;
    assign wlast_error   = wlast_error_reg;

    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        beat_cnt_next    = beat_cnt_reg;
        wlast_error_next = wlast_error_reg;

        // Pointers wrap naturally because the depth is a power of two.
        if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;

        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (w_hs) begin
            beat_cnt_next = pop ? 8'd0 : beat_cnt_reg + 8'd1;
            if (sx4.wlast != beat_last) wlast_error_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            beat_cnt_reg    <= '0;
            wlast_error_reg <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            beat_cnt_reg    <= beat_cnt_next;
            wlast_error_reg <= wlast_error_next;
        end
    end

    // Length storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) len_mem[wr_ptr_reg] <= rx4.awlen;
    end

endmodule

// File: tb/tb_munoc_axi4_write_order_guard.sv
// Directed bench for the write order guard: source queues feed the upstream side and
// scoreboard queues hold the AW/W traffic expected downstream.
module tb_munoc_axi4_write_order_guard;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] pending_count;
    logic       wlast_error;

    munoc_axi4_write_order_guard_if #(.BW_AXI_TID(4), .BW_PLATFORM_ADDR(32), .BW_NODE_DATA(32)) up ();
    munoc_axi4_write_order_guard_if #(.BW_AXI_TID(4), .BW_PLATFORM_ADDR(32), .BW_NODE_DATA(32)) dn ();

    munoc_axi4_write_order_guard #(
        .BW_AXI_TID(4), .BW_PLATFORM_ADDR(32), .BW_NODE_DATA(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sx4(up),
        .rx4(dn),
        .pending_count(pending_count),
        .wlast_error(wlast_error)
    );

    always #5 clk = ~clk;

    aw_t aw_src[$];
    aw_t exp_aw[$];
    w_t  w_src[$];
    w_t  exp_w[$];

    int  checks = 0;
    int  errors = 0;
    int  beats_total = 0;
    int  burst_beats = 0;
    bit  aw_rdy = 1'b1;
    bit  w_rdy = 1'b1;
    bit  w_rand = 1'b0;
    bit  neg_aw_fire, neg_w_fire, neg_w_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_aw(input int len);
        aw_t a;
        a.id    = 4'($urandom_range(0, 15));
        a.addr  = $urandom;
        a.len   = 8'(len);
        a.size  = 3'd2;
        a.burst = 2'b01;
        aw_src.push_back(a);
        exp_aw.push_back(a);
    endtask

    // mode 0: master WLAST correct, 1: WLAST only on beat 0, 2: WLAST never asserted
    task automatic add_w(input int len, input int mode);
        w_t s;
        w_t e;
        for (int i = 0; i <= len; i++) begin
            s.data = $urandom;
            s.strb = 4'($urandom_range(0, 15));
            s.last = (mode == 0) ? (i == len) : (mode == 1) ? (i == 0) : 1'b0;
            e      = s;
            e.last = (i == len);
            w_src.push_back(s);
            exp_w.push_back(e);
        end
    endtask

    // One clock: drive upstream/downstream inputs, observe handshakes mid-cycle, return #1 after the edge.
    task automatic step();
        aw_t a;
        w_t  w;
        w_t  e;
        aw_t x;
        up.awvalid = (aw_src.size() != 0);
        if (aw_src.size() != 0) begin
            a = aw_src[0];
            up.awid = a.id; up.awaddr = a.addr; up.awlen = a.len;
            up.awsize = a.size; up.awburst = a.burst;
        end
        up.wvalid = (w_src.size() != 0);
        if (w_src.size() != 0) begin
            w = w_src[0];
            up.wdata = w.data; up.wstrb = w.strb; up.wlast = w.last;
        end
        dn.awready = aw_rdy;
        dn.wready  = w_rand ? 1'($urandom_range(0, 1)) : w_rdy;

        @(negedge clk);
        neg_aw_fire = dn.awvalid && dn.awready;
        neg_w_fire  = dn.wvalid && dn.wready;
        neg_w_last  = neg_w_fire && dn.wlast;
        if (neg_aw_fire) begin
            x = '{id: dn.awid, addr: dn.awaddr, len: dn.awlen, size: dn.awsize, burst: dn.awburst};
            if (exp_aw.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
            else chk("aw_payload", 64'(x), 64'(exp_aw.pop_front()));
            $display("AW  id=%0h addr=%08h len=%0d pending=%0d", x.id, x.addr, x.len, pending_count);
        end
        if (neg_w_fire) begin
            w = '{data: dn.wdata, strb: dn.wstrb, last: dn.wlast};
            if (exp_w.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
            else begin
                e = exp_w.pop_front();
                chk("w_beat", 64'(w), 64'(e));
            end
            beats_total++;
            burst_beats++;
            if (dn.wlast) begin
                $display("W   burst complete beats=%0d", burst_beats);
                burst_beats = 0;
            end
        end
        if (up.awvalid && up.awready && aw_src.size() != 0) void'(aw_src.pop_front());
        if (up.wvalid && up.wready && w_src.size() != 0) void'(w_src.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input string tag);
        for (int k = 0; k < budget && (exp_aw.size() != 0 || exp_w.size() != 0); k++) step();
        chk(tag, 64'(exp_aw.size() + exp_w.size()), 64'(0));
    endtask

    initial begin
        int b0;
        rst = 1'b1;
        up.awvalid = 1'b0; up.wvalid = 1'b0; up.bready = 1'b1;
        up.awid = '0; up.awaddr = '0; up.awlen = '0; up.awsize = '0; up.awburst = '0;
        up.wdata = '0; up.wstrb = '0; up.wlast = 1'b0;
        dn.awready = 1'b1; dn.wready = 1'b1;
        dn.bvalid = 1'b1; dn.bid = 4'h5; dn.bresp = 2'b10;

        // Reset holds every handshake low even with traffic offered on both sides.
        add_aw(0);
        add_w(0, 0);
        step();
        step();
        chk("rst_pending", 64'(pending_count), 64'(0));
        chk("rst_wlast_error", 64'(wlast_error), 64'(0));
        chk("rst_rx4awvalid", 64'(dn.awvalid), 64'(0));
        chk("rst_sx4awready", 64'(up.awready), 64'(0));
        chk("rst_rx4wvalid", 64'(dn.wvalid), 64'(0));
        chk("rst_sx4wready", 64'(up.wready), 64'(0));
        chk("rst_sx4bvalid", 64'(up.bvalid), 64'(0));
        chk("rst_rx4bready", 64'(dn.bready), 64'(0));
        rst = 1'b0;
        drain(20, "post_rst_drain");
        chk("post_rst_pending", 64'(pending_count), 64'(0));

        // B channel passes straight through.
        #1;
        chk("b_valid", 64'(up.bvalid), 64'(1));
        chk("b_id_resp", 64'({up.bid, up.bresp}), 64'({4'h5, 2'b10}));
        up.bready = 1'b0;
        #1;
        chk("b_ready_low", 64'(dn.bready), 64'(0));
        up.bready = 1'b1;
        dn.bvalid = 1'b0;
        #1;
        chk("b_valid_low", 64'(up.bvalid), 64'(0));

        // W beats offered five cycles before their AW.
        add_w(3, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wfirst_hold_valid", 64'(dn.wvalid), 64'(0));
            chk("wfirst_hold_ready", 64'(up.wready), 64'(0));
        end
        add_aw(3);
        step();
        chk("wfirst_aw_fire", 64'(neg_aw_fire), 64'(1));
        chk("wfirst_no_bypass", 64'(neg_w_fire), 64'(0));
        chk("wfirst_pending1", 64'(pending_count), 64'(1));
        step();
        chk("wfirst_beat0_next", 64'(neg_w_fire), 64'(1));
        drain(20, "wfirst_drain");
        chk("wfirst_pending0", 64'(pending_count), 64'(0));

        // Outstanding limit with W stalled.
        w_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            add_aw(0);
            add_w(0, 0);
        end
        for (int i = 0; i < 6; i++) step();
        chk("limit_pending4", 64'(pending_count), 64'(4));
        chk("limit_awready0", 64'(up.awready), 64'(0));
        chk("limit_aw_left", 64'(aw_src.size()), 64'(1));
        w_rdy = 1'b1;
        step();
        chk("limit_w_pop", 64'(neg_w_last), 64'(1));
        chk("limit_no_same_cycle_aw", 64'(neg_aw_fire), 64'(0));
        chk("limit_pending3", 64'(pending_count), 64'(3));
        step();
        chk("limit_fifth_aw", 64'(neg_aw_fire), 64'(1));
        chk("limit_pending3_pushpop", 64'(pending_count), 64'(3));
        drain(40, "limit_drain");
        chk("limit_pending0", 64'(pending_count), 64'(0));

        // AW of the next burst accepted on the same cycle as the previous burst's last beat.
        add_aw(2);
        add_w(2, 0);
        step();
        aw_rdy = 1'b0;
        add_aw(1);
        add_w(1, 0);
        step();
        step();
        aw_rdy = 1'b1;
        step();
        chk("pushpop_aw", 64'(neg_aw_fire), 64'(1));
        chk("pushpop_last", 64'(neg_w_last), 64'(1));
        chk("pushpop_pending", 64'(pending_count), 64'(1));
        drain(20, "pushpop_drain");
        chk("pushpop_pending0", 64'(pending_count), 64'(0));

        // Early WLAST from the master.
        chk("err_clear_before", 64'(wlast_error), 64'(0));
        add_aw(1);
        add_w(1, 1);
        drain(20, "early_drain");
        chk("early_error_set", 64'(wlast_error), 64'(1));
        step();
        step();
        chk("early_error_sticky", 64'(wlast_error), 64'(1));

        // Missing WLAST after a reset clears the flag.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_cleared_by_rst", 64'(wlast_error), 64'(0));
        add_aw(0);
        add_w(0, 2);
        drain(20, "missing_drain");
        chk("missing_error_set", 64'(wlast_error), 64'(1));

        // Maximum-length burst under random downstream backpressure.
        w_rand = 1'b1;
        b0 = beats_total;
        add_aw(255);
        add_w(255, 0);
        drain(3000, "maxlen_drain");
        chk("maxlen_beats", 64'(beats_total - b0), 64'(256));
        chk("maxlen_pending0", 64'(pending_count), 64'(0));
        w_rand = 1'b0;

        // Reset in the middle of an 8-beat burst.
        dn.bvalid = 1'b1;
        b0 = beats_total;
        add_aw(7);
        add_w(7, 0);
        for (int k = 0; k < 20 && beats_total - b0 < 3; k++) step();
        chk("midrst_beats_before", 64'(beats_total - b0), 64'(3));
        rst = 1'b1;
        step();
        chk("midrst_rx4wvalid", 64'(dn.wvalid), 64'(0));
        chk("midrst_sx4wready", 64'(up.wready), 64'(0));
        chk("midrst_sx4awready", 64'(up.awready), 64'(0));
        chk("midrst_rx4awvalid", 64'(dn.awvalid), 64'(0));
        chk("midrst_sx4bvalid", 64'(up.bvalid), 64'(0));
        chk("midrst_pending", 64'(pending_count), 64'(0));
        chk("midrst_wlast_error", 64'(wlast_error), 64'(0));
        aw_src.delete();
        w_src.delete();
        exp_aw.delete();
        exp_w.delete();
        burst_beats = 0;
        dn.bvalid = 1'b0;
        rst = 1'b0;
        add_aw(2);
        add_w(2, 0);
        drain(20, "midrst_fresh_drain");
        chk("midrst_fresh_pending0", 64'(pending_count), 64'(0));
        chk("midrst_fresh_no_error", 64'(wlast_error), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/munoc_axi4_write_order_guard.md
# munoc_axi4_write_order_guard

AXI4 write-channel ordering guard placed directly upstream of the MUNOC AXI4 master network interface's rx4aw*/rx4w*/rx4b* ports. AXI4 lets a master present W beats before their AW; the guard holds each W beat until its AW has been accepted downstream. It tracks every outstanding burst's AWLEN in a small FIFO and enforces WLAST on the expected beat. A sticky error flags masters whose WLAST disagrees with AWLEN.

## Interface
Parameters:
- BW_AXI_TID, 4, AXI ID width
- BW_PLATFORM_ADDR, 32, address width
- BW_NODE_DATA, 32, data width (multiple of 8)
- MAX_OUTSTANDING, 4, AW accepted but W burst not finished; power of two, ≥2

Ports (AXI widths: ALEN 8, ASIZE 3, ABURST 2, WSTRB BW_NODE_DATA/8, BRESP 2):
- clk  in  1  block clock
- rst  in  1  reset, synchronous, active-high
- sx4awid/awaddr/awlen/awsize/awburst  in  per AXI  upstream AW payload
- sx4awvalid  in  1 ; sx4awready  out  1
- sx4wdata/wstrb  in  per AXI ; sx4wlast  in  1 ; sx4wvalid  in  1 ; sx4wready  out  1
- sx4bid  out  BW_AXI_TID ; sx4bresp  out  2 ; sx4bvalid  out  1 ; sx4bready  in  1
- rx4awid/awaddr/awlen/awsize/awburst  out  per AXI  downstream AW payload to NI
- rx4awvalid  out  1 ; rx4awready  in  1
- rx4wdata/wstrb  out  per AXI ; rx4wlast  out  1 ; rx4wvalid  out  1 ; rx4wready  in  1
- rx4bid  in  BW_AXI_TID ; rx4bresp  in  2 ; rx4bvalid  in  1 ; rx4bready  out  1
- pending_count  out  clog2(MAX_OUTSTANDING)+1  bursts with AW accepted, W not finished
- wlast_error  out  1  sticky WLAST/AWLEN mismatch flag

## Operation
- Length FIFO: depth MAX_OUTSTANDING, entries 8 bits (AWLEN). Push on downstream AW handshake (rx4awvalid & rx4awready); pop on downstream W handshake carrying rx4wlast=1.
- pending_count = FIFO occupancy.
- AW path, combinational payload pass-through:
  - rx4awvalid = sx4awvalid & !full
  - sx4awready = rx4awready & !full
- W path, combinational payload pass-through gated by !empty (registered occupancy):
  - rx4wvalid = sx4wvalid & !empty
  - sx4wready = rx4wready & !empty
- Beat counter (8 bits): increments on each downstream W handshake; cleared on the handshake where rx4wlast=1.
- rx4wlast = (beat_cnt == fifo_head). Forwarded WLAST always reflects AWLEN, never sx4wlast.
- Error detection: on a W handshake, sx4wlast != (beat_cnt == fifo_head) sets wlast_error. It stays set until rst.
  - Early WLAST: forwarded as a non-last beat; the burst continues.
  - Missing WLAST: the final beat is forced last.
- B path: pure combinational pass-through (sx4b* = rx4b*, rx4bready = sx4bready). The guard does not count or check B.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.

## Timing
- Zero-cycle latency on AW, W and B; no pipeline registers in the data path.
- A W beat whose AW completes in cycle N is first forwardable in cycle N+1, because empty is registered. No same-cycle AW→W bypass.
- Full (pending_count == MAX_OUTSTANDING): sx4awready = 0 and rx4awvalid = 0. A pop in the same cycle does not unblock AW until N+1.
- Empty: sx4wready = 0 and rx4wvalid = 0.
- FIFO pointers wrap modulo MAX_OUTSTANDING. AWLEN = 255 requires 256 beats; the beat counter does not overflow because it clears on the last beat.
- Reset, including mid-burst, while rst = 1 and on the following edge:
  - FIFO emptied; beat_cnt, pending_count and wlast_error = 0.
  - rx4awvalid, rx4wvalid, sx4awready, sx4wready forced 0.
  - The B pass-through is also forced idle: sx4bvalid = 0, rx4bready = 0.
  - A partially transferred burst is discarded; no completion is generated.

## Test plan
- W-before-AW: drive 4 W beats (AWLEN=3) starting 5 cycles before AW. Required: rx4wvalid stays 0 until the cycle after the AW handshake; beats exit in order with rx4wlast only on the 4th; pending_count goes 0→1→0.
- Outstanding limit (MAX_OUTSTANDING=4, W stalled): issue 5 AWs with AWLEN=0. Required: 4 accepted, sx4awready=0 with pending_count=4; the 5th is accepted the cycle after the first W completes.
- Simultaneous push/pop: AW handshake and final W beat of the previous burst in the same cycle. Required: pending_count unchanged, correct head AWLEN used next.
- WLAST mismatch: AWLEN=1, master asserts WLAST on beat 0. Required: rx4wlast=0 on beat 0, 1 on beat 1, wlast_error=1 and sticky. Second case: AWLEN=0 with sx4wlast=0. Required: rx4wlast=1 and the error is set.
- Max-length burst: AWLEN=255 under random rx4wready. Required: exactly 256 beats, rx4wlast only on beat 256, FIFO empty afterwards.
- Reset mid-burst: assert rst after beat 2 of an AWLEN=7 burst. Required: the next cycle shows all valid/ready outputs 0, pending_count=0, wlast_error=0; a fresh AW+W burst completes normally after rst drops.
